// File: rtl/timer_responder_pkg.sv
// Shared constants for the machine-timer responder: register offsets,
// ctrl bit positions and the bus handshake state encoding.
package timer_responder_pkg;

    localparam logic [1:0] OFF_MTIME    = 2'd0;
    localparam logic [1:0] OFF_MTIMECMP = 2'd1;
    localparam logic [1:0] OFF_CTRL     = 2'd2;
    localparam logic [1:0] OFF_PRESCALE = 2'd3;

    localparam int CTRL_COUNT_EN = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_W        = 2;
    localparam int PRESCALE_W    = 16;

    typedef enum logic [1:0] {
        HS_IDLE   = 2'd0,
        HS_ACCESS = 2'd1,
        HS_DONE   = 2'd2
    } hs_state_e;

endpackage

// File: rtl/bus_handshake_fsm.sv
// Responder-side handshake: latches a request, holds busy for BUSY_CYCLES
// cycles, pulses commit on the final busy cycle, then spends one cycle in DONE.
module bus_handshake_fsm
    import timer_responder_pkg::*;
#(
    parameter int BUSY_CYCLES = 2,
    parameter int DATA_W      = 64,
    parameter int SEL_W       = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  chip_select,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [DATA_W/8-1:0]   byte_en,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DATA_W-1:0]     write_data,
    output logic                  busy,
    output logic                  commit,
    output logic                  req_rd,
    output logic                  req_wr,
    output logic [DATA_W/8-1:0]   req_byte_en,
    output logic [SEL_W-1:0]      req_sel,
    output logic [DATA_W-1:0]     req_data
);

    localparam int               CNT_W    = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_CYCLES - 1);

    hs_state_e             state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  accept;
    logic                  rd_reg, wr_reg;
    logic [DATA_W/8-1:0]   be_reg;
    logic [SEL_W-1:0]      sel_reg;
    logic [DATA_W-1:0]     data_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= HS_IDLE;
            cnt_reg   <= '0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            be_reg    <= '0;
            sel_reg   <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                rd_reg   <= rd_en;
                wr_reg   <= wr_en;
                be_reg   <= byte_en;
                sel_reg  <= sel;
                data_reg <= write_data;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            HS_IDLE: begin
                if (chip_select && (rd_en || wr_en)) begin
                    accept     = 1'b1;
                    state_next = HS_ACCESS;
                    cnt_next   = CNT_LOAD;
                end
            end
            HS_ACCESS: begin
                if (cnt_reg == '0) begin
                    commit     = 1'b1;
                    state_next = HS_DONE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            // Initiator may still hold its enables here; ignore them for a cycle.
            HS_DONE: state_next = HS_IDLE;
            default: state_next = HS_IDLE;
        endcase
    end

    assign busy        = (state_reg == HS_ACCESS);
    assign req_rd      = rd_reg;
    assign req_wr      = wr_reg;
    assign req_byte_en = be_reg;
    assign req_sel     = sel_reg;
    assign req_data    = data_reg;

endmodule

// File: rtl/timer_responder.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, mtimecmp compare,
// ctrl register and a registered interrupt, behind a busy-handshake bus port.
module timer_responder
    import timer_responder_pkg::*;
#(
    parameter int BUSY_CYCLES = 2,
    parameter int DATA_SIZE   = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   chip_select,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [DATA_SIZE/8-1:0] byte_en,
    input  logic [4:0]             address,
    input  logic [DATA_SIZE-1:0]   write_data,
    output logic [DATA_SIZE-1:0]   read_data,
    output logic                   busy,
    output logic                   timer_irq
);

    localparam int LANES = DATA_SIZE / 8;

    logic                 hs_commit;
    logic                 req_rd, req_wr;
    logic [LANES-1:0]     req_be;
    logic [1:0]           req_sel;
    logic [DATA_SIZE-1:0] req_data;

    logic                 unused_addr_bits;
    assign unused_addr_bits = ^address[2:0];

    bus_handshake_fsm #(
        .BUSY_CYCLES (BUSY_CYCLES),
        .DATA_W      (DATA_SIZE),
        .SEL_W       (2)
    ) u_handshake (
        .clock       (clock),
        .reset       (reset),
        .chip_select (chip_select),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .byte_en     (byte_en),
        .sel         (address[4:3]),
        .write_data  (write_data),
        .busy        (busy),
        .commit      (hs_commit),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .req_byte_en (req_be),
        .req_sel     (req_sel),
        .req_data    (req_data)
    );

    logic [DATA_SIZE-1:0]  mtime_reg, mtime_next;
    logic [DATA_SIZE-1:0]  mtimecmp_reg, mtimecmp_next;
    logic [CTRL_W-1:0]     ctrl_reg, ctrl_next;
    logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
    logic [PRESCALE_W-1:0] presc_cnt_reg, presc_cnt_next;
    logic [DATA_SIZE-1:0]  read_data_reg, read_data_next;
    logic                  irq_reg, irq_next;

    // Current value of the register addressed by the latched request.
    logic [DATA_SIZE-1:0]  sel_value;
    always_comb begin
        sel_value = '0;
        case (req_sel)
            OFF_MTIME:    sel_value = mtime_reg;
            OFF_MTIMECMP: sel_value = mtimecmp_reg;
            OFF_CTRL:     sel_value = {{(DATA_SIZE-CTRL_W){1'b0}}, ctrl_reg};
            OFF_PRESCALE: sel_value = {{(DATA_SIZE-PRESCALE_W){1'b0}}, prescale_reg};
            default:      sel_value = '0;
        endcase
    end

    logic [DATA_SIZE-1:0]  wr_merged;
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign wr_merged[gi*8 +: 8] = req_be[gi] ? req_data[gi*8 +: 8] : sel_value[gi*8 +: 8];
    end

    logic do_write, do_read;
    logic wr_mtime, wr_mtimecmp, wr_ctrl, wr_prescale;
    logic tick;

    // An all-zero byte_en completes the handshake but touches nothing.
    assign do_write    = hs_commit & req_wr & (|req_be);
    assign do_read     = hs_commit & req_rd & ~req_wr;
    assign wr_mtime    = do_write & (req_sel == OFF_MTIME);
    assign wr_mtimecmp = do_write & (req_sel == OFF_MTIMECMP);
    assign wr_ctrl     = do_write & (req_sel == OFF_CTRL);
    assign wr_prescale = do_write & (req_sel == OFF_PRESCALE);

    always_comb begin
        presc_cnt_next = presc_cnt_reg;
        tick           = 1'b0;
        if (ctrl_reg[CTRL_COUNT_EN]) begin
            if (presc_cnt_reg == prescale_reg) begin
                presc_cnt_next = '0;
                tick           = 1'b1;
            end else begin
                presc_cnt_next = presc_cnt_reg + PRESCALE_W'(1);
            end
        end
        if (wr_prescale) begin
            presc_cnt_next = '0;
        end

        // A software write to mtime wins over the increment on the same edge.
        mtime_next     = wr_mtime    ? wr_merged : mtime_reg + {{(DATA_SIZE-1){1'b0}}, tick};
        mtimecmp_next  = wr_mtimecmp ? wr_merged : mtimecmp_reg;
        ctrl_next      = wr_ctrl     ? wr_merged[CTRL_W-1:0] : ctrl_reg;
        prescale_next  = wr_prescale ? wr_merged[PRESCALE_W-1:0] : prescale_reg;
        read_data_next = do_read     ? sel_value : read_data_reg;
        irq_next       = ctrl_reg[CTRL_IRQ_EN] & (mtime_reg >= mtimecmp_reg);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mtime_reg     <= '0;
            mtimecmp_reg  <= '1;
            ctrl_reg      <= '0;
            prescale_reg  <= '0;
            presc_cnt_reg <= '0;
            read_data_reg <= '0;
            irq_reg       <= 1'b0;
        end else begin
            mtime_reg     <= mtime_next;
            mtimecmp_reg  <= mtimecmp_next;
            ctrl_reg      <= ctrl_next;
            prescale_reg  <= prescale_next;
            presc_cnt_reg <= presc_cnt_next;
            read_data_reg <= read_data_next;
            irq_reg       <= irq_next;
        end
    end

    assign read_data = read_data_reg;
    assign timer_irq = irq_reg;

endmodule

// File: doc/timer_responder.md
Name: timer_responder

Overview:
- Memory-mapped machine timer: the responder (memory) end of the core's mem_rd_en/mem_wr_en/mem_byte_en/mem_busy bus.
- Sits beside ROM and single_port_ram behind memory_controller, and is selected by a chip_select from the controller.
- Holds a 64-bit free-running mtime, an mtimecmp compare value, a control register and a prescaler.
- Drives a registered timer interrupt line toward the core.

Parameters:
- BUSY_CYCLES, 2, number of cycles busy stays high per transaction; legal range ≥1.
- DATA_SIZE, 64, register and bus width; only 64 is supported.

Ports:
- clock  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- chip_select  input  1  transaction is addressed to this block.
- rd_en  input  1  read request.
- wr_en  input  1  write request.
- byte_en  input  8  write byte-lane enables; bit k selects wr_data[8k+7:8k].
- address  input  5  byte address; only address[4:3] is decoded, address[2:0] is ignored.
- write_data  input  64  write data.
- read_data  output  64  read data; valid when busy falls, held until the next read completes.
- busy  output  1  transaction in progress.
- timer_irq  output  1  timer interrupt, registered.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clock, reset).
- Register map, selected by address[4:3]:
  - 0 = mtime.
  - 1 = mtimecmp.
  - 2 = ctrl: bit0 count_en, bit1 irq_en; other bits read 0.
  - 3 = prescale: low 16 bits used, upper bits read 0.
- Reset values:
  - mtime = 0; mtimecmp = all ones; ctrl = 0; prescale = 0.
  - read_data = 0; busy = 0; timer_irq = 0.
  - FSM goes to IDLE and the internal prescale counter is 0.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: at an edge with chip_select & (rd_en | wr_en), latch rd_en, wr_en, byte_en, address[4:3] and write_data; go to ACCESS; busy = 1 after that edge; load cycle counter = BUSY_CYCLES-1.
  - ACCESS: counter decrements each edge. At the edge where counter == 0:
    - perform the write, or capture read_data with the pre-edge register value;
    - busy = 0 after that edge;
    - go to DONE.
  - DONE: lasts exactly one cycle; requests are ignored; then go to IDLE. This absorbs the initiator dropping its enables combinationally in the cycle busy falls.
- Transaction timing: busy is high for exactly BUSY_CYCLES cycles. Inputs may change after acceptance; only the latched values are used.
- Read/write priority: if rd_en and wr_en are both high, only the write is performed and read_data is unchanged.
- Writes: only lanes with byte_en[k] = 1 are modified; byte_en = 0 completes the handshake with no change.
- Counting:
  - When count_en = 1, the prescale counter increments each cycle.
  - When it equals prescale, it clears and mtime increments by 1.
  - mtime wraps from 2^64-1 to 0.
  - When count_en = 0, the counter holds.
- Write to mtime in the same edge as an increment: the written lanes take write_data; the increment is dropped for that edge.
- Write to prescale: the prescale counter clears.
- Interrupt: timer_irq <= irq_en & (mtime >= mtimecmp) each edge, unsigned compare on current (pre-edge) values, giving one cycle of latency.
- Reset mid-transaction: the pending write is discarded; busy drops the cycle after reset is sampled.

Decomposition:
- Package timer_responder_pkg holds:
  - register offset constants (OFF_MTIME = 2'd0, OFF_MTIMECMP = 2'd1, OFF_CTRL = 2'd2, OFF_PRESCALE = 2'd3);
  - ctrl bit indices;
  - the FSM state encoding.
- One sub-module, bus_handshake_fsm, owns IDLE/ACCESS/DONE, the busy counter and the request latches, and outputs a one-cycle commit strobe. It is reusable by future peripherals.
- Register file and counter logic stay in the top level.

Test Plan:
- Reset, then read offset 0x08 with BUSY_CYCLES = 2 -> busy high exactly 2 cycles; read_data = 0xFFFF_FFFF_FFFF_FFFF at the busy fall; a 1-cycle DONE follows.
- Write ctrl = 0x1, prescale = 3, then read mtime 40 cycles later -> value equals elapsed enabled cycles / 4, checked against a bench model.
- Write mtimecmp = 0x0000_0000_0000_0010 with byte_en = 0x01, then read -> 0xFFFF_FFFF_FFFF_FF10 (only lane 0 changed).
- mtime preset to 0xFFFF_FFFF_FFFF_FFFF, count_en = 1, prescale = 0 -> reads 0 after 1 cycle; with irq_en = 1 and mtimecmp = 5, timer_irq rises exactly 1 cycle after mtime reaches 5.
- rd_en and wr_en both high on mtimecmp with 0x1234 -> register = 0x1234 and read_data unchanged. Separately, a write of mtime = 0x100 landing on an increment edge reads back 0x100.
- Reset asserted while busy, during a write of ctrl = 0x3 -> busy = 0 next cycle; ctrl reads 0; timer_irq stays 0.
